// File: rtl/window_extrema_tracker_if.sv
// Sample-in / window-result-out bundle for window_extrema_tracker.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready are both high.
interface window_extrema_tracker_if #(
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_max;
  logic [3:0]       out_min;
  logic [IDX_W-1:0] out_max_idx;
  logic [IDX_W:0]   out_max_hits;
  logic [IDX_W:0]   out_count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_max_idx, out_max_hits, out_count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_max, out_min, out_max_idx, out_max_hits, out_count
  );
endinterface

// File: rtl/window_extrema_tracker.sv
// Windowed max/min tracker: folds 4-bit samples into WIN-sample windows and
// presents max, min, first max index, max hit count and sample count per window.
module magnitude_comparator #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_gt_b,
  output logic         a_lt_b,
  output logic         a_eq_b
);
  assign a_gt_b = (a > b);
  assign a_lt_b = (a < b);
  assign a_eq_b = (a == b);
endmodule

module window_extrema_tracker #(
  parameter int WIN   = 8,
  parameter int IDX_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  window_extrema_tracker_if.slave  bus,
  output logic                     dbg_state_o,
  output logic [2:0]               dbg_max_cmp_o,
  output logic [2:0]               dbg_min_cmp_o
);
  localparam int CW = IDX_W + 1;
  localparam logic [IDX_W:0] WIN_CNT = CW'(WIN);

  typedef enum logic {ST_ACC = 1'b0, ST_DONE = 1'b1} state_e;

  state_e           state_q;
  logic [IDX_W:0]   cnt_q,  cnt_d;
  logic [3:0]       max_q,  max_d;
  logic [3:0]       min_q,  min_d;
  logic [IDX_W-1:0] idx_q,  idx_d;
  logic [IDX_W:0]   hits_q, hits_d;

  logic [3:0]       res_max_q, res_min_q;
  logic [IDX_W-1:0] res_idx_q;
  logic [IDX_W:0]   res_hits_q, res_cnt_q;

  logic max_gt, max_lt, max_eq;
  logic min_gt, min_lt, min_eq;
  logic accept, close;

  magnitude_comparator #(.W(4)) u_cmp_max (
    .a(bus.in_data), .b(max_q), .a_gt_b(max_gt), .a_lt_b(max_lt), .a_eq_b(max_eq)
  );

  magnitude_comparator #(.W(4)) u_cmp_min (
    .a(bus.in_data), .b(min_q), .a_gt_b(min_gt), .a_lt_b(min_lt), .a_eq_b(min_eq)
  );

  assign bus.in_ready = (state_q == ST_ACC) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    cnt_d  = cnt_q;
    max_d  = max_q;
    min_d  = min_q;
    idx_d  = idx_q;
    hits_d = hits_q;
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      // The first sample seeds the window; comparator flags against stale registers are ignored.
      if (cnt_q == '0) begin
        max_d  = bus.in_data;
        min_d  = bus.in_data;
        idx_d  = '0;
        hits_d = {{IDX_W{1'b0}}, 1'b1};
      end else begin
        if (max_gt) begin
          max_d  = bus.in_data;
          idx_d  = cnt_q[IDX_W-1:0];
          hits_d = {{IDX_W{1'b0}}, 1'b1};
        end else if (max_eq) begin
          hits_d = hits_q + 1'b1;
        end
        if (min_lt) begin
          min_d = bus.in_data;
        end
      end
    end
  end

  // A flush that arrives with a sample closes the window after that sample is folded in.
  assign close = (state_q == ST_ACC) &&
                 ((accept && (cnt_d == WIN_CNT)) || (bus.flush && (cnt_d != '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      max_q      <= '0;
      min_q      <= '0;
      idx_q      <= '0;
      hits_q     <= '0;
      res_max_q  <= '0;
      res_min_q  <= '0;
      res_idx_q  <= '0;
      res_hits_q <= '0;
      res_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          cnt_q  <= cnt_d;
          max_q  <= max_d;
          min_q  <= min_d;
          idx_q  <= idx_d;
          hits_q <= hits_d;
          if (close) begin
            state_q    <= ST_DONE;
            res_max_q  <= max_d;
            res_min_q  <= min_d;
            res_idx_q  <= idx_d;
            res_hits_q <= hits_d;
            res_cnt_q  <= cnt_d;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.out_max      = res_max_q;
  assign bus.out_min      = res_min_q;
  assign bus.out_max_idx  = res_idx_q;
  assign bus.out_max_hits = res_hits_q;
  assign bus.out_count    = res_cnt_q;

  assign dbg_state_o   = state_q;
  assign dbg_max_cmp_o = {max_gt, max_eq, max_lt};
  assign dbg_min_cmp_o = {min_gt, min_eq, min_lt};
endmodule

// File: tb/tb_window_extrema_tracker.sv
// Directed bench for window_extrema_tracker (WIN=4, IDX_W=2): queue-based window
// model checked every cycle, plus hand-computed window results checked at each handshake.
module tb_window_extrema_tracker;
  localparam int WIN   = 4;
  localparam int IDX_W = 2;
  localparam int CW    = IDX_W + 1;
  localparam int RW    = 8 + IDX_W + 2 * CW;

  logic       clk;
  logic       rst;
  logic       dbg_state;
  logic [2:0] dbg_max_cmp;
  logic [2:0] dbg_min_cmp;

  window_extrema_tracker_if #(.IDX_W(IDX_W)) bus ();

  window_extrema_tracker #(.WIN(WIN), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_max_cmp_o(dbg_max_cmp),
    .dbg_min_cmp_o(dbg_min_cmp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] pack(input int mx, input int mn, input int ix,
                                         input int hits, input int cnt);
    logic [3:0] a;
    logic [3:0] b;
    logic [IDX_W-1:0] c;
    logic [CW-1:0] d;
    logic [CW-1:0] e;
    a = 4'(mx); b = 4'(mn); c = IDX_W'(ix); d = CW'(hits); e = CW'(cnt);
    return {a, b, c, d, e};
  endfunction

  function automatic logic [RW-1:0] dut_res();
    return {bus.out_max, bus.out_min, bus.out_max_idx, bus.out_max_hits, bus.out_count};
  endfunction

  // ---------------- behavioural model ----------------
  int            win_q[$];
  bit            m_busy = 1'b0;
  logic [RW-1:0] m_res  = '0;

  function automatic logic [RW-1:0] summarize();
    int mx = -1;
    int mn = 16;
    int ix = 0;
    int h  = 0;
    foreach (win_q[i]) begin
      if (win_q[i] > mx) begin mx = win_q[i]; ix = i; end
      if (win_q[i] < mn) mn = win_q[i];
    end
    foreach (win_q[i]) if (win_q[i] == mx) h++;
    return pack(mx, mn, ix, h, win_q.size());
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      win_q.delete();
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (bus.out_ready) begin
        m_busy = 1'b0;
        win_q.delete();
      end
    end else begin
      if (bus.in_valid) win_q.push_back(int'(bus.in_data));
      if (win_q.size() == WIN || (bus.flush && win_q.size() > 0)) begin
        m_res  = summarize();
        m_busy = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int mx;
    int mn;
    logic d_gt, d_eq, d_lt;
    chk("in_ready", 32'(bus.in_ready), 32'(!rst && !m_busy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_busy));
    if (m_busy) chk("result_vs_model", 32'(dut_res()), 32'(m_res));
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("exp_q_underflow", 32'd1, 32'd0);
      else chk("window_literal", 32'(dut_res()), 32'(exp_q.pop_front()));
    end
    if (!rst && !m_busy && bus.in_valid && win_q.size() > 0) begin
      mx = 0; mn = 15;
      foreach (win_q[i]) begin
        if (win_q[i] > mx) mx = win_q[i];
        if (win_q[i] < mn) mn = win_q[i];
      end
      d_gt = int'(bus.in_data) > mx; d_eq = int'(bus.in_data) == mx; d_lt = int'(bus.in_data) < mx;
      chk("cmp_max_flags", 32'(dbg_max_cmp), 32'({d_gt, d_eq, d_lt}));
      d_gt = int'(bus.in_data) > mn; d_eq = int'(bus.in_data) == mn; d_lt = int'(bus.in_data) < mn;
      chk("cmp_min_flags", 32'(dbg_min_cmp), 32'({d_gt, d_eq, d_lt}));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic fl);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.flush    = fl;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 32'd1, 32'd0);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (!bus.out_valid && !m_busy) begin done = 1'b1; break; end
      tick();
    end
    if (!done) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 32'(dut_res()), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(4'(a), 1'b0); send(4'(b), 1'b0); send(4'(c), 1'b0); send(4'(d), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    do_reset(2);

    // full window with a repeated max
    exp_q.push_back(pack(9, 1, 1, 2, 4));
    send4(3, 9, 9, 1);
    wait_idle();

    // all equal
    exp_q.push_back(pack(5, 5, 0, 4, 4));
    send4(5, 5, 5, 5);
    wait_idle();

    // backpressure: next window's samples wait out the held result
    bus.out_ready = 1'b0;
    exp_q.push_back(pack(7, 2, 1, 1, 4));
    exp_q.push_back(pack(12, 3, 3, 1, 4));
    send4(2, 7, 4, 6);
    fork
      begin repeat (5) @(posedge clk); #1; bus.out_ready = 1'b1; end
      send4(8, 8, 3, 12);
    join
    wait_idle();

    // flush alone, then flush with a sample, then flush on an empty window
    exp_q.push_back(pack(15, 0, 0, 1, 2));
    send(4'd15, 1'b0); send(4'd0, 1'b0); pulse_flush();
    wait_idle();
    exp_q.push_back(pack(15, 0, 0, 2, 3));
    send(4'd15, 1'b0); send(4'd0, 1'b0); send(4'd15, 1'b1);
    wait_idle();
    pulse_flush();
    repeat (3) tick();

    // reset mid-window discards the partial window
    send(4'd1, 1'b0); send(4'd2, 1'b0);
    do_reset(1);
    exp_q.push_back(pack(9, 2, 2, 1, 4));
    send4(6, 2, 9, 4);
    wait_idle();

    // reset while a result is held, then a flush while held is ignored
    bus.out_ready = 1'b0;
    send4(1, 1, 1, 1);
    @(negedge clk);
    chk("done_held", 32'(bus.out_valid), 32'd1);
    #1;
    do_reset(1);
    bus.out_ready = 1'b1;

    bus.out_ready = 1'b0;
    exp_q.push_back(pack(3, 2, 0, 3, 4));
    send4(3, 3, 3, 2);
    pulse_flush();
    repeat (2) tick();
    bus.out_ready = 1'b1;
    wait_idle();

    // extremes and ties
    exp_q.push_back(pack(15, 0, 1, 2, 4));
    send4(0, 15, 15, 0);
    wait_idle();

    repeat (3) tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
